// File: rtl/wr_pps_monitor.sv
// PPS stability monitor: measures the PPS period, checks TAI continuity, tracks lock
// and fires a one-cycle trigger at an armed TAI second once the PPS is locked.
module wr_pps_monitor #(
  parameter int G_CLK_FREQ   = 62500000,
  parameter int G_TOL        = 2,
  parameter int G_LOCK_COUNT = 4
) (
  input  logic        clk_sys_i,
  input  logic        reset_i,
  input  logic        pps_i,
  input  logic [9:0]  tm_tai_i,
  input  logic        arm_i,
  input  logic [9:0]  arm_tai_i,
  input  logic        clr_i,
  output logic        trig_o,
  output logic        armed_o,
  output logic        locked_o,
  output logic [31:0] period_o,
  output logic [15:0] missing_cnt_o,
  output logic [15:0] period_err_cnt_o,
  output logic [15:0] tai_err_cnt_o
);

  localparam int               RUN_W   = $clog2(G_LOCK_COUNT + 1);
  localparam logic [RUN_W-1:0] LOCK_N  = RUN_W'(G_LOCK_COUNT);
  localparam logic [31:0]      PER_MIN = 32'(G_CLK_FREQ - G_TOL);
  localparam logic [31:0]      PER_MAX = 32'(G_CLK_FREQ + G_TOL);
  localparam logic [31:0]      MISS_AT = 32'(G_CLK_FREQ + G_TOL + 1);

  typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  state_t           state;
  logic             pps_p1;
  logic             pps_p2;
  logic [9:0]       tai_p1;
  logic [31:0]      cycle_cnt;
  logic [RUN_W-1:0] good_run;
  logic [9:0]       last_tai;
  logic [9:0]       target;

  logic             vld_p1;
  logic             tracking;
  logic             per_bad;
  logic             tai_bad;
  logic             edge_err;
  logic             miss_evt;
  logic             fire;
  logic [RUN_W-1:0] run_next;

  // Stage p1 -> edge decision: all checks are evaluated against the edge-cycle view
  always_comb begin
    vld_p1   = pps_p1 & ~pps_p2;
    tracking = (state != ACQUIRE);
    per_bad  = (cycle_cnt < PER_MIN) || (cycle_cnt > PER_MAX);
    tai_bad  = (tai_p1 != last_tai + 10'd1);
    edge_err = per_bad || tai_bad;
    run_next = (good_run == LOCK_N) ? good_run : good_run + RUN_W'(1);
    miss_evt = tracking && !vld_p1 && (cycle_cnt == MISS_AT);
    // An arm request on the matching edge replaces the target instead of firing
    fire     = tracking && vld_p1 && !edge_err && (run_next == LOCK_N) &&
               armed_o && !arm_i && (tai_p1 == target);
  end

  // Stage p2 -> registered status
  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state            <= ACQUIRE;
      pps_p1           <= 1'b0;
      pps_p2           <= 1'b0;
      tai_p1           <= '0;
      cycle_cnt        <= '0;
      good_run         <= '0;
      last_tai         <= '0;
      target           <= '0;
      trig_o           <= 1'b0;
      armed_o          <= 1'b0;
      locked_o         <= 1'b0;
      period_o         <= '0;
      missing_cnt_o    <= '0;
      period_err_cnt_o <= '0;
      tai_err_cnt_o    <= '0;
    end else begin
      pps_p1    <= pps_i;
      pps_p2    <= pps_p1;
      tai_p1    <= tm_tai_i;
      cycle_cnt <= vld_p1 ? 32'd1 : sat_inc32(cycle_cnt);
      trig_o    <= fire;

      if (arm_i) begin
        target  <= arm_tai_i;
        armed_o <= 1'b1;
      end else if (fire) begin
        armed_o <= 1'b0;
      end

      case (state)
        ACQUIRE: begin
          if (vld_p1) begin
            last_tai <= tai_p1;
            good_run <= '0;
            locked_o <= 1'b0;
            state    <= TRACK;
          end
        end
        TRACK, LOCKED: begin
          if (vld_p1) begin
            period_o <= cycle_cnt;
            last_tai <= tai_p1;
            if (edge_err) begin
              good_run <= '0;
              locked_o <= 1'b0;
              state    <= TRACK;
            end else begin
              good_run <= run_next;
              locked_o <= (run_next == LOCK_N);
              state    <= (run_next == LOCK_N) ? LOCKED : TRACK;
            end
          end else if (miss_evt) begin
            good_run <= '0;
            locked_o <= 1'b0;
            state    <= ACQUIRE;
          end
        end
        default: begin
          good_run <= '0;
          locked_o <= 1'b0;
          state    <= ACQUIRE;
        end
      endcase

      if (clr_i) begin
        missing_cnt_o    <= '0;
        period_err_cnt_o <= '0;
        tai_err_cnt_o    <= '0;
      end else begin
        if (miss_evt)
          missing_cnt_o <= sat_inc16(missing_cnt_o);
        if (tracking && vld_p1 && per_bad)
          period_err_cnt_o <= sat_inc16(period_err_cnt_o);
        if (tracking && vld_p1 && tai_bad)
          tai_err_cnt_o <= sat_inc16(tai_err_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_wr_pps_monitor.sv
// Self-checking bench for wr_pps_monitor with a per-second behavioural model.
module tb_wr_pps_monitor;

  logic        clk_sys_i = 1'b0;
  logic        reset_i   = 1'b1;
  logic        pps_i     = 1'b0;
  logic [9:0]  tm_tai_i  = '0;
  logic        arm_i     = 1'b0;
  logic [9:0]  arm_tai_i = '0;
  logic        clr_i     = 1'b0;
  logic        trig_o;
  logic        armed_o;
  logic        locked_o;
  logic [31:0] period_o;
  logic [15:0] missing_cnt_o;
  logic [15:0] period_err_cnt_o;
  logic [15:0] tai_err_cnt_o;

  always #5 clk_sys_i = ~clk_sys_i;

  wr_pps_monitor #(
    .G_CLK_FREQ  (100),
    .G_TOL       (2),
    .G_LOCK_COUNT(3)
  ) dut (
    .clk_sys_i       (clk_sys_i),
    .reset_i         (reset_i),
    .pps_i           (pps_i),
    .tm_tai_i        (tm_tai_i),
    .arm_i           (arm_i),
    .arm_tai_i       (arm_tai_i),
    .clr_i           (clr_i),
    .trig_o          (trig_o),
    .armed_o         (armed_o),
    .locked_o        (locked_o),
    .period_o        (period_o),
    .missing_cnt_o   (missing_cnt_o),
    .period_err_cnt_o(period_err_cnt_o),
    .tai_err_cnt_o   (tai_err_cnt_o)
  );

  int checks = 0;
  int errors = 0;
  int since = 1000;
  int pps_left = 0;
  int trig_seen = 0;

  // Behavioural model, updated once per PPS second
  bit         m_track;
  int         m_good;
  bit         m_locked;
  logic [9:0] m_last;
  int         m_period;
  bit         m_armed;
  logic [9:0] m_target;
  int         m_miss, m_perr, m_terr;
  bit         m_fire;
  int         m_trig_total = 0;

  always @(negedge clk_sys_i) if (trig_o === 1'b1) trig_seen++;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_sys_i);
    #1;
    since++;
    if (pps_left > 0) begin
      pps_left--;
      if (pps_left == 0) pps_i = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_track = 0; m_good = 0; m_locked = 0; m_last = '0; m_period = 0;
    m_armed = 0; m_target = '0; m_miss = 0; m_perr = 0; m_terr = 0; m_fire = 0;
  endtask

  task automatic model_edge(input int g, input logic [9:0] tai, input bit arm_e,
                            input logic [9:0] a_tai, input bit clr_e);
    logic [9:0] nxt;
    bit pbad, tbad;
    m_fire = 0;
    if (m_track && g >= 104) begin
      if (m_miss < 65535) m_miss++;
      m_track = 0; m_locked = 0; m_good = 0;
    end
    if (!m_track) begin
      m_track = 1; m_good = 0; m_locked = 0; m_last = tai;
    end else begin
      nxt = m_last + 10'd1;
      pbad = (g < 98) || (g > 102);
      tbad = (tai != nxt);
      m_period = g;
      m_last = tai;
      if (pbad && m_perr < 65535) m_perr++;
      if (tbad && m_terr < 65535) m_terr++;
      if (pbad || tbad) begin
        m_good = 0; m_locked = 0;
      end else begin
        if (m_good < 3) m_good++;
        m_locked = (m_good == 3);
        if (m_locked && m_armed && !arm_e && tai == m_target) begin
          m_fire = 1; m_armed = 0; m_trig_total++;
        end
      end
    end
    if (arm_e) begin m_armed = 1; m_target = a_tai; end
    if (clr_e) begin m_miss = 0; m_perr = 0; m_terr = 0; end
  endtask

  // Rise pps_i gap cycles after the previous rise; returns when the edge's status is visible.
  task automatic send_pps(input int gap, input logic [9:0] tai, input int width,
                          input bit arm_e, input logic [9:0] a_tai, input bit clr_e);
    int g;
    while (since < gap) step();
    g = since;
    pps_i = 1'b1; tm_tai_i = tai; pps_left = width; since = 0;
    step();
    arm_i = arm_e; arm_tai_i = a_tai; clr_i = clr_e;
    step();
    arm_i = 1'b0; clr_i = 1'b0;
    model_edge(g, tai, arm_e, a_tai, clr_e);
  endtask

  task automatic arm(input logic [9:0] t);
    arm_i = 1'b1; arm_tai_i = t;
    step();
    arm_i = 1'b0;
    m_armed = 1; m_target = t;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; pps_i = 1'b0; pps_left = 0; arm_i = 1'b0; clr_i = 1'b0;
    repeat (3) step();
    reset_i = 1'b0;
    since = 1000;
    model_reset();
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) step();
    checks++; if (trig_o !== 1'b0) begin errors++; $display("FAIL rst_trig: got %0b want 0", trig_o); end
    checks++; if (armed_o !== 1'b0) begin errors++; $display("FAIL rst_armed: got %0b want 0", armed_o); end
    checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL rst_locked: got %0b want 0", locked_o); end
    checks++; if (period_o !== 32'd0) begin errors++; $display("FAIL rst_period: got %0d want 0", period_o); end
    checks++; if (missing_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_miss: got %0d want 0", missing_cnt_o); end
    checks++; if (period_err_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_perr: got %0d want 0", period_err_cnt_o); end
    checks++; if (tai_err_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_terr: got %0d want 0", tai_err_cnt_o); end
    reset_i = 1'b0;
    since = 1000;
    model_reset();
  endtask

  task automatic test_lock();
    for (int i = 0; i < 5; i++) begin
      send_pps(100, 10'(7 + i), 1, 0, '0, 0);
      checks++;
      if (locked_o !== (i >= 3)) begin
        errors++; $display("FAIL lock_edge%0d: locked_o=%0b want %0b", i + 1, locked_o, (i >= 3));
      end
      if (i == 0) begin
        checks++; if (period_o !== 32'd0) begin errors++; $display("FAIL lock_acq_period: got %0d want 0", period_o); end
      end
    end
    checks++; if (period_o !== 32'd100) begin errors++; $display("FAIL lock_period: got %0d want 100", period_o); end
    checks++;
    if ({missing_cnt_o, period_err_cnt_o, tai_err_cnt_o} !== 48'd0) begin
      errors++; $display("FAIL lock_counters: got %0d/%0d/%0d want 0/0/0", missing_cnt_o, period_err_cnt_o, tai_err_cnt_o);
    end
  endtask

  task automatic test_tolerance();
    send_pps(102, 10'd12, 2, 0, '0, 0);
    checks++; if (period_o !== 32'd102) begin errors++; $display("FAIL tol_p102: got %0d want 102", period_o); end
    checks++; if (locked_o !== 1'b1 || period_err_cnt_o !== 16'd0) begin
      errors++; $display("FAIL tol_102_ok: locked=%0b perr=%0d want 1/0", locked_o, period_err_cnt_o); end
    send_pps(103, 10'd13, 1, 0, '0, 0);
    checks++; if (period_err_cnt_o !== 16'd1) begin errors++; $display("FAIL tol_103_perr: got %0d want 1", period_err_cnt_o); end
    checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL tol_103_unlock: got %0b want 0", locked_o); end
    for (int i = 0; i < 3; i++) begin
      send_pps(100, 10'(14 + i), 1, 0, '0, 0);
      checks++;
      if (locked_o !== (i == 2)) begin errors++; $display("FAIL tol_relock%0d: got %0b want %0b", i, locked_o, (i == 2)); end
    end
    send_pps(98, 10'd17, 1, 0, '0, 0);
    checks++; if (locked_o !== 1'b1 || period_err_cnt_o !== 16'd1) begin
      errors++; $display("FAIL tol_98_ok: locked=%0b perr=%0d want 1/1", locked_o, period_err_cnt_o); end
    send_pps(97, 10'd18, 1, 0, '0, 0);
    checks++; if (locked_o !== 1'b0 || period_err_cnt_o !== 16'd2) begin
      errors++; $display("FAIL tol_97_err: locked=%0b perr=%0d want 0/2", locked_o, period_err_cnt_o); end
    for (int i = 0; i < 3; i++) send_pps(100, 10'(19 + i), 1, 0, '0, 0);
    checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL tol_relock_final: got %0b want 1", locked_o); end
  endtask

  task automatic test_long_pulse();
    send_pps(100, 10'd22, 30, 0, '0, 0);
    send_pps(100, 10'd23, 1, 0, '0, 0);
    checks++; if (period_o !== 32'd100) begin errors++; $display("FAIL long_period: got %0d want 100", period_o); end
    checks++; if (locked_o !== 1'b1 || period_err_cnt_o !== 16'd2 || tai_err_cnt_o !== 16'd0) begin
      errors++; $display("FAIL long_status: locked=%0b perr=%0d terr=%0d want 1/2/0", locked_o, period_err_cnt_o, tai_err_cnt_o); end
  endtask

  task automatic test_tai();
    do_reset();
    send_pps(100, 10'd20, 1, 0, '0, 0);
    send_pps(100, 10'd21, 1, 0, '0, 0);
    checks++; if (tai_err_cnt_o !== 16'd0) begin errors++; $display("FAIL tai_seq_ok: got %0d want 0", tai_err_cnt_o); end
    send_pps(100, 10'd23, 1, 0, '0, 0);
    checks++; if (tai_err_cnt_o !== 16'd1) begin errors++; $display("FAIL tai_skip: got %0d want 1", tai_err_cnt_o); end
    checks++; if (period_err_cnt_o !== 16'd0) begin errors++; $display("FAIL tai_skip_perr: got %0d want 0", period_err_cnt_o); end
    do_reset();
    send_pps(100, 10'd1021, 1, 0, '0, 0);
    send_pps(100, 10'd1022, 1, 0, '0, 0);
    send_pps(100, 10'd1023, 1, 0, '0, 0);
    send_pps(100, 10'd0, 1, 0, '0, 0);
    checks++; if (tai_err_cnt_o !== 16'd0 || locked_o !== 1'b1) begin
      errors++; $display("FAIL tai_wrap: terr=%0d locked=%0b want 0/1", tai_err_cnt_o, locked_o); end
    send_pps(100, 10'd1, 1, 0, '0, 0);
    checks++; if (tai_err_cnt_o !== 16'd0) begin errors++; $display("FAIL tai_after_wrap: got %0d want 0", tai_err_cnt_o); end
  endtask

  task automatic test_missing();
    do_reset();
    for (int i = 0; i < 4; i++) send_pps(100, 10'(40 + i), 1, 0, '0, 0);
    checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL miss_prelock: got %0b want 1", locked_o); end
    while (since < 104) step();
    checks++; if (missing_cnt_o !== 16'd0 || locked_o !== 1'b1) begin
      errors++; $display("FAIL miss_early: miss=%0d locked=%0b want 0/1", missing_cnt_o, locked_o); end
    step();
    checks++; if (missing_cnt_o !== 16'd1 || locked_o !== 1'b0) begin
      errors++; $display("FAIL miss_at_103: miss=%0d locked=%0b want 1/0", missing_cnt_o, locked_o); end
    repeat (50) step();
    checks++; if (missing_cnt_o !== 16'd1) begin errors++; $display("FAIL miss_once: got %0d want 1", missing_cnt_o); end
    send_pps(0, 10'd50, 1, 0, '0, 0);
    checks++; if (tai_err_cnt_o !== 16'd0 || period_err_cnt_o !== 16'd0 || period_o !== 32'd100) begin
      errors++; $display("FAIL miss_acq_edge: terr=%0d perr=%0d period=%0d want 0/0/100", tai_err_cnt_o, period_err_cnt_o, period_o); end
    send_pps(100, 10'd51, 1, 0, '0, 0);
    checks++; if (tai_err_cnt_o !== 16'd0 || period_err_cnt_o !== 16'd0 || missing_cnt_o !== 16'd1) begin
      errors++; $display("FAIL miss_recover: terr=%0d perr=%0d miss=%0d want 0/0/1", tai_err_cnt_o, period_err_cnt_o, missing_cnt_o); end
  endtask

  task automatic test_trigger();
    int base;
    do_reset();
    for (int i = 0; i < 4; i++) send_pps(100, 10'(25 + i), 1, 0, '0, 0);
    base = trig_seen;
    arm(10'd30);
    checks++; if (armed_o !== 1'b1) begin errors++; $display("FAIL trig_armed: got %0b want 1", armed_o); end
    send_pps(100, 10'd29, 1, 0, '0, 0);
    checks++; if (trig_o !== 1'b0 || armed_o !== 1'b1) begin
      errors++; $display("FAIL trig_early: trig=%0b armed=%0b want 0/1", trig_o, armed_o); end
    send_pps(100, 10'd30, 1, 0, '0, 0);
    checks++; if (trig_o !== 1'b1 || armed_o !== 1'b0) begin
      errors++; $display("FAIL trig_fire: trig=%0b armed=%0b want 1/0", trig_o, armed_o); end
    step();
    checks++; if (trig_o !== 1'b0) begin errors++; $display("FAIL trig_width: got %0b want 0", trig_o); end
    checks++; if (trig_seen - base !== 1) begin errors++; $display("FAIL trig_count1: got %0d want 1", trig_seen - base); end
    arm(10'd32);
    send_pps(100, 10'd31, 1, 0, '0, 0);
    send_pps(100, 10'd32, 1, 1, 10'd34, 0);
    checks++; if (trig_o !== 1'b0 || armed_o !== 1'b1) begin
      errors++; $display("FAIL trig_arm_on_edge: trig=%0b armed=%0b want 0/1", trig_o, armed_o); end
    send_pps(100, 10'd33, 1, 0, '0, 0);
    send_pps(100, 10'd34, 1, 0, '0, 0);
    checks++; if (trig_o !== 1'b1 || armed_o !== 1'b0) begin
      errors++; $display("FAIL trig_overwrite: trig=%0b armed=%0b want 1/0", trig_o, armed_o); end
    step();
    checks++; if (trig_seen - base !== 2) begin errors++; $display("FAIL trig_count2: got %0d want 2", trig_seen - base); end
    arm(10'd36);
    send_pps(97, 10'd35, 1, 0, '0, 0);
    checks++; if (locked_o !== 1'b0 || armed_o !== 1'b1) begin
      errors++; $display("FAIL trig_persist: locked=%0b armed=%0b want 0/1", locked_o, armed_o); end
    send_pps(100, 10'd36, 1, 0, '0, 0);
    checks++; if (trig_o !== 1'b0 || armed_o !== 1'b1) begin
      errors++; $display("FAIL trig_unlocked: trig=%0b armed=%0b want 0/1", trig_o, armed_o); end
  endtask

  task automatic test_clear_reset();
    int base;
    send_pps(100, 10'd38, 1, 0, '0, 0);
    checks++; if (tai_err_cnt_o !== 16'd1) begin errors++; $display("FAIL clr_pre: terr=%0d want 1", tai_err_cnt_o); end
    send_pps(100, 10'd40, 1, 0, '0, 1);
    checks++; if (tai_err_cnt_o !== 16'd0 || period_err_cnt_o !== 16'd0) begin
      errors++; $display("FAIL clr_priority: terr=%0d perr=%0d want 0/0", tai_err_cnt_o, period_err_cnt_o); end
    arm(10'd60);
    repeat (20) step();
    do_reset();
    checks++; if (armed_o !== 1'b0) begin errors++; $display("FAIL rst_disarm: got %0b want 0", armed_o); end
    base = trig_seen;
    for (int i = 0; i < 6; i++) send_pps(100, 10'(56 + i), 1, 0, '0, 0);
    step();
    checks++; if (trig_seen !== base) begin errors++; $display("FAIL rst_no_trig: pulses=%0d want 0", trig_seen - base); end
    checks++; if (locked_o !== 1'b1) begin errors++; $display("FAIL rst_relock: got %0b want 1", locked_o); end
  endtask

  task automatic test_random();
    int r, gap, width;
    logic [9:0] tai, a_tai;
    bit arm_e, clr_e;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      gap = $urandom_range(98, 102);
      else if (r < 80) gap = ($urandom_range(0, 1) == 0) ? 97 : 103;
      else if (r < 86) gap = $urandom_range(104, 110);
      else             gap = 100;
      tai = ($urandom_range(0, 99) < 92) ? m_last + 10'd1 : 10'($urandom_range(0, 1023));
      width = $urandom_range(1, 4);
      if ($urandom_range(0, 9) == 0) arm(m_last + 10'($urandom_range(1, 4)));
      arm_e = ($urandom_range(0, 19) == 0);
      a_tai = m_last + 10'($urandom_range(1, 4));
      clr_e = ($urandom_range(0, 19) == 0);
      send_pps(gap, tai, width, arm_e, a_tai, clr_e);
      checks++; if (period_o !== 32'(m_period)) begin errors++; $display("FAIL rnd%0d_period: got %0d want %0d", n, period_o, m_period); end
      checks++; if (locked_o !== m_locked) begin errors++; $display("FAIL rnd%0d_locked: got %0b want %0b", n, locked_o, m_locked); end
      checks++; if (armed_o !== m_armed) begin errors++; $display("FAIL rnd%0d_armed: got %0b want %0b", n, armed_o, m_armed); end
      checks++; if (trig_o !== m_fire) begin errors++; $display("FAIL rnd%0d_trig: got %0b want %0b", n, trig_o, m_fire); end
      checks++; if (missing_cnt_o !== 16'(m_miss)) begin errors++; $display("FAIL rnd%0d_miss: got %0d want %0d", n, missing_cnt_o, m_miss); end
      checks++; if (period_err_cnt_o !== 16'(m_perr)) begin errors++; $display("FAIL rnd%0d_perr: got %0d want %0d", n, period_err_cnt_o, m_perr); end
      checks++; if (tai_err_cnt_o !== 16'(m_terr)) begin errors++; $display("FAIL rnd%0d_terr: got %0d want %0d", n, tai_err_cnt_o, m_terr); end
    end
    repeat (3) step();
    checks++; if (trig_seen !== m_trig_total) begin
      errors++; $display("FAIL trig_total: pulses=%0d want %0d", trig_seen, m_trig_total); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_tolerance();
    test_long_pulse();
    test_tai();
    test_missing();
    test_trigger();
    test_clear_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wr_pps_monitor.md
WR_PPS_MONITOR -- requirements
Module: wr_pps_monitor

Interface
REQ-001 SHALL have parameter G_CLK_FREQ, default 62500000, nominal clk_sys_i cycles per PPS period.
REQ-002 SHALL have parameter G_TOL, default 2, allowed ± deviation in cycles from G_CLK_FREQ.
REQ-003 SHALL have parameter G_LOCK_COUNT, default 4, consecutive good periods needed for lock.
REQ-004 SHALL have port clk_sys_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_i, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port pps_i, input, 1 bit, PPS from the timing core; a pulse may be high for one or more cycles.
REQ-007 SHALL have port tm_tai_i, input, 10 bits, low TAI seconds, valid alongside pps_i.
REQ-008 SHALL have port arm_i, input, 1 bit, single-cycle request to arm a trigger.
REQ-009 SHALL have port arm_tai_i, input, 10 bits, target TAI second, sampled when arm_i=1.
REQ-010 SHALL have port clr_i, input, 1 bit, clears the error counters.
REQ-011 SHALL have port trig_o, output, 1 bit, single-cycle trigger pulse.
REQ-012 SHALL have port armed_o, output, 1 bit, high while a trigger is pending.
REQ-013 SHALL have port locked_o, output, 1 bit, high while PPS is stable.
REQ-014 SHALL have port period_o, output, 32 bits, last measured PPS period in cycles.
REQ-015 SHALL have ports missing_cnt_o, period_err_cnt_o and tai_err_cnt_o, each output, 16 bits, error event counters.

Function
REQ-016 SHALL register pps_i into p1, then p1 into p2; an edge is the cycle where p1=1 and p2=0; tm_tai_i SHALL be registered alongside p1, and that registered value is "edge TAI".
REQ-017 SHALL run a 32-bit, saturating cycle counter; it is set to 1 on the edge cycle and increments on every other cycle; at an edge, measured period = counter value before it is set to 1.
REQ-018 SHALL use FSM states ACQUIRE, TRACK and LOCKED; reset state is ACQUIRE.
REQ-019 In ACQUIRE, an edge SHALL perform no checks, store edge TAI as last_tai, and move to TRACK with good_run=0.
REQ-020 In TRACK or LOCKED, at an edge: period_o SHALL update to the measured period.
REQ-021 In TRACK or LOCKED, at an edge: if the period is outside [G_CLK_FREQ-G_TOL, G_CLK_FREQ+G_TOL], period_err_cnt SHALL increment.
REQ-022 In TRACK or LOCKED, at an edge: if edge TAI != (last_tai+1) mod 1024, tai_err_cnt SHALL increment; last_tai SHALL then be set to edge TAI.
REQ-023 At an edge with any error, good_run SHALL be set to 0 and the state to TRACK; otherwise good_run SHALL increment, saturating at G_LOCK_COUNT.
REQ-024 When good_run reaches G_LOCK_COUNT, the state SHALL become LOCKED; locked_o SHALL be 1 only in LOCKED.
REQ-025 In TRACK or LOCKED, when the counter reaches G_CLK_FREQ+G_TOL+1 without an edge, missing_cnt SHALL increment once, the state SHALL become ACQUIRE, and good_run SHALL be set to 0.
REQ-026 All status outputs SHALL be registered and SHALL update on the cycle after the edge cycle, 2 cycles after pps_i is first sampled high.
REQ-027 All error counters SHALL saturate at 0xFFFF.
REQ-028 clr_i SHALL zero all three counters; clr_i takes priority over a same-cycle increment.
REQ-029 arm_i SHALL latch arm_tai_i into the target and set armed_o=1; arm_i while armed SHALL overwrite the target.
REQ-030 At an edge with no error, state LOCKED after the update, armed_o=1, and edge TAI == target: trig_o SHALL pulse for 1 cycle at the REQ-026 timing, and armed_o SHALL clear in the same cycle.
REQ-031 arm_i coincident with a matching edge SHALL latch the new target and SHALL NOT fire trig_o that cycle.
REQ-032 An armed target SHALL persist through loss of lock and SHALL fire only when REQ-030 holds.
REQ-033 A pps_i held high for many cycles SHALL count as one edge.

Reset
REQ-034 Under reset_i=1: state=ACQUIRE, p1/p2=0, counter=0, good_run=0, last_tai=0, target=0, trig_o=0, armed_o=0, locked_o=0, period_o=0, all counters=0.
REQ-035 Asserting reset_i mid-period SHALL discard any pending trigger.
REQ-036 After reset release, the first edge SHALL be treated as an ACQUIRE edge.

Verification (G_CLK_FREQ=100, G_TOL=2, G_LOCK_COUNT=3)
REQ-037 Lock test: 5 PPS edges spaced 100 cycles, TAI 7..11 -> locked_o=1 from the 4th edge's update; period_o=100; all counters 0.
REQ-038 Tolerance test: periods of 102, then 103, while locked -> 102 is accepted; 103 gives period_err_cnt=1, locked_o=0, and lock returns after 3 further good periods.
REQ-039 Missing test: no PPS after a locked edge -> missing_cnt=1 exactly 103 cycles after that edge; state ACQUIRE; the next edge produces no error.
REQ-040 TAI test: TAI sequence 20, 21, 23 at 100-cycle spacing -> tai_err_cnt=1; TAI wrap 1023 -> 0 gives no error.
REQ-041 Trigger test: arm target 30 while locked, edges at TAI 29 and 30 -> one trig_o pulse 2 cycles after pps_i rises at TAI 30; armed_o=0 afterwards; arm_i on the matching edge cycle gives no pulse.
REQ-042 Reset/clear test: clr_i coincident with an error -> counter=0; reset_i while armed -> armed_o=0 and no trig_o at the target second.
